// File: rtl/result_collector_pkg.sv
// Shared constants, FSM encoding and slice-insertion helper for the
// part-serial result collector.
package result_collector_pkg;

   localparam int PART_W = 6;
   localparam int NPARTS = 3;
   localparam int NRES   = 9;
   localparam int RES_W  = PART_W * NPARTS;

   // Last legal part index and last legal result index of a frame.
   localparam logic [1:0] LAST_PART = 2'(NPARTS - 1);
   localparam logic [3:0] LAST_RES  = 4'(NRES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Return word with the slice at position idx replaced (part 0 = LSBs).
   function automatic logic [RES_W-1:0] insert_slice(
      input logic [RES_W-1:0]  word,
      input logic [1:0]        idx,
      input logic [PART_W-1:0] slice
   );
      logic [RES_W-1:0] w;
      w = word;
      case (idx)
         2'd0:    w[PART_W-1:0]          = slice;
         2'd1:    w[2*PART_W-1:PART_W]   = slice;
         2'd2:    w[3*PART_W-1:2*PART_W] = slice;
         default: w = word;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/result_collector_if.sv
// Beat input, result output and status signals of the result collector.
// master = controller/consumer side, slave = the collector itself.
interface result_collector_if;
   import result_collector_pkg::*;

   logic              start;
   logic              part_valid;
   logic [4:0]        res_idx;
   logic [1:0]        part_idx;
   logic [PART_W-1:0] part_data;
   logic              res_valid;
   logic              res_ready;
   logic [RES_W-1:0]  res_data;
   logic [3:0]        res_addr;
   logic              busy;
   logic              frame_done;
   logic              err;

   modport slave (
      input  start, part_valid, res_idx, part_idx, part_data, res_ready,
      output res_valid, res_data, res_addr, busy, frame_done, err
   );

   modport master (
      output start, part_valid, res_idx, part_idx, part_data, res_ready,
      input  res_valid, res_data, res_addr, busy, frame_done, err
   );

endinterface

// File: rtl/result_collector_buf.sv
// NRES x RES_W result register file: one synchronous write port, one
// asynchronous read port. Contents are not reset; every entry is written
// during collection before the drain phase reads it.
module result_buf
   import result_collector_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [3:0]       waddr,
   input  logic [RES_W-1:0] wdata,
   input  logic [3:0]       raddr,
   output logic [RES_W-1:0] rdata
);

   logic [RES_W-1:0] mem_r [NRES];

   // Store a completed result; addresses beyond the last entry are ignored.
   always_ff @(posedge clk) begin
      if (we && (waddr <= LAST_RES)) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Out-of-range read addresses (pointer parked past the end) return zero.
   always_comb begin
      rdata = {RES_W{1'b0}};
      if (raddr <= LAST_RES) begin
         rdata = mem_r[raddr];
      end else begin
         rdata = {RES_W{1'b0}};
      end
   end

endmodule

// File: rtl/result_collector.sv
// Result collector: checks the controller's beat order, reassembles each
// result from its part slices into a buffer, then drains the buffer in
// index order over a valid/ready interface.
module result_collector
   import result_collector_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   result_collector_if.slave  bus
);

   state_t           state_r;
   state_t           state_next_s;
   logic [3:0]       exp_res_r;
   logic [1:0]       exp_part_r;
   logic [3:0]       rd_ptr_r;
   logic [RES_W-1:0] asm_r;
   logic             err_r;

   logic             beat_match_s;
   logic             beat_accept_s;
   logic             word_done_s;
   logic             frame_open_s;
   logic             xfer_s;
   logic             err_set_s;
   logic [RES_W-1:0] asm_next_s;
   logic [RES_W-1:0] rd_data_s;

   // Assembly word with the current beat's slice merged in; also the data
   // written to the buffer on the edge that completes a result.
   assign asm_next_s   = insert_slice(asm_r, exp_part_r, bus.part_data);
   assign beat_match_s = (bus.res_idx == {1'b0, exp_res_r}) &&
                         (bus.part_idx == exp_part_r);

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_next_s  = state_r;
      beat_accept_s = 1'b0;
      word_done_s   = 1'b0;
      frame_open_s  = 1'b0;
      xfer_s        = 1'b0;
      err_set_s     = 1'b0;
      case (state_r)
         IDLE: begin
            // Stray beats before a frame opens are simply ignored.
            if (bus.start) begin
               frame_open_s = 1'b1;
               state_next_s = COLLECT;
            end else begin
               state_next_s = IDLE;
            end
         end
         COLLECT: begin
            if (bus.part_valid) begin
               if (beat_match_s) begin
                  beat_accept_s = 1'b1;
                  if (exp_part_r == LAST_PART) begin
                     word_done_s = 1'b1;
                     if (exp_res_r == LAST_RES) begin
                        state_next_s = DRAIN;
                     end else begin
                        state_next_s = COLLECT;
                     end
                  end else begin
                     state_next_s = COLLECT;
                  end
               end else begin
                  // Out-of-order beat: drop it, flag the frame, keep going.
                  err_set_s    = 1'b1;
                  state_next_s = COLLECT;
               end
            end else begin
               state_next_s = COLLECT;
            end
         end
         DRAIN: begin
            // Any beat here is an overrun of the controller.
            err_set_s = bus.part_valid;
            if (bus.res_ready) begin
               xfer_s = 1'b1;
               if (rd_ptr_r == LAST_RES) begin
                  state_next_s = DONE;
               end else begin
                  state_next_s = DRAIN;
               end
            end else begin
               state_next_s = DRAIN;
            end
         end
         DONE: begin
            err_set_s    = bus.part_valid;
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Expected result/part counters tracking the controller's fixed order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_res_r  <= 4'd0;
         exp_part_r <= 2'd0;
      end else if (frame_open_s) begin
         exp_res_r  <= 4'd0;
         exp_part_r <= 2'd0;
      end else if (beat_accept_s) begin
         if (word_done_s) begin
            exp_part_r <= 2'd0;
            exp_res_r  <= exp_res_r + 4'd1;
         end else begin
            exp_part_r <= exp_part_r + 2'd1;
         end
      end else begin
         exp_res_r  <= exp_res_r;
         exp_part_r <= exp_part_r;
      end
   end

   // Assembly register accumulates the slices of the result in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_r <= {RES_W{1'b0}};
      end else if (beat_accept_s) begin
         asm_r <= asm_next_s;
      end else begin
         asm_r <= asm_r;
      end
   end

   // Drain read pointer; parks past the end in DONE and wraps on exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r <= 4'd0;
      end else if (frame_open_s || (state_r == DONE)) begin
         rd_ptr_r <= 4'd0;
      end else if (xfer_s) begin
         rd_ptr_r <= rd_ptr_r + 4'd1;
      end else begin
         rd_ptr_r <= rd_ptr_r;
      end
   end

   // Sticky protocol error, cleared only when a new frame opens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (frame_open_s) begin
         err_r <= 1'b0;
      end else if (err_set_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   result_buf u_buf (
      .clk   (clk),
      .we    (word_done_s),
      .waddr (exp_res_r),
      .wdata (asm_next_s),
      .raddr (rd_ptr_r),
      .rdata (rd_data_s)
   );

   // Outputs decode directly from registered state and pointer.
   assign bus.res_valid  = (state_r == DRAIN);
   assign bus.res_data   = (state_r == DRAIN) ? rd_data_s : {RES_W{1'b0}};
   assign bus.res_addr   = (state_r == DRAIN) ? rd_ptr_r  : 4'd0;
   assign bus.busy       = (state_r != IDLE);
   assign bus.frame_done = (state_r == DONE);
   assign bus.err        = err_r;

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: stimulus pushes the expected
// drain sequence into a queue, a negedge monitor compares every presented
// result against the queue head and pops it on each accepted transfer.
module tb_result_collector;
   import result_collector_pkg::*;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   xfer_count;
   exp_t exp_q[$];

   result_collector_if bus ();

   result_collector dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endfunction

   // Expected 18-bit word for result r: slices 3r, 3r+1, 3r+2 from LSB up.
   function automatic int exp_word(input int r);
      logic [5:0] s0, s1, s2;
      s0 = 6'(3 * r);
      s1 = 6'(3 * r + 1);
      s2 = 6'(3 * r + 2);
      return int'({s2, s1, s0});
   endfunction

   task automatic push_frame();
      exp_t e;
      for (int r = 0; r < 9; r++) begin
         e.addr = r;
         e.data = exp_word(r);
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every presented result with the queue head.
   always @(negedge clk) begin
      if (!rst && bus.res_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            check("res_addr", int'(bus.res_addr), exp_q[0].addr);
            check("res_data", int'(bus.res_data), exp_q[0].data);
            if (bus.res_ready) begin
               void'(exp_q.pop_front());
               xfer_count++;
            end
         end
      end
   end

   task automatic start_frame();
      tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy_after_start", int'(bus.busy), 1);
      check("err_after_start", int'(bus.err), 0);
   endtask

   // 27 in-order beats; optional bad beat (wrong part) before beat bad_at,
   // optional stray start pulse alongside beat 13.
   task automatic send_frame(input int bad_at, input bit stray_start);
      int r;
      int p;
      for (int k = 0; k < 27; k++) begin
         r = k / 3;
         p = k % 3;
         if (k == bad_at) begin
            tick();
            bus.part_valid = 1'b1;
            bus.res_idx    = 5'(r);
            bus.part_idx   = 2'(p + 1);
            bus.part_data  = 6'h3f;
            tick();
            bus.part_valid = 1'b0;
            check("err_after_bad_beat", int'(bus.err), 1);
         end
         tick();
         bus.start      = stray_start && (k == 13);
         bus.part_valid = 1'b1;
         bus.res_idx    = 5'(r);
         bus.part_idx   = 2'(p);
         bus.part_data  = 6'(3 * r + p);
      end
      tick();
      bus.start      = 1'b0;
      bus.part_valid = 1'b0;
      check("res_valid_after_last_beat", int'(bus.res_valid), 1);
   endtask

   // Drain with ready pattern (always, or 1-of-3); check done timing/flags.
   task automatic drain(input bit bp, input int exp_cycles, input int exp_err);
      int c;
      c = 0;
      while (!bus.frame_done && c < 200) begin
         bus.res_ready = bp ? (c % 3 == 0) : 1'b1;
         tick();
         c++;
      end
      check("frame_done_pulse", int'(bus.frame_done), 1);
      check("drain_cycles", c, exp_cycles);
      check("queue_drained", exp_q.size(), 0);
      check("busy_in_done", int'(bus.busy), 1);
      check("err_in_done", int'(bus.err), exp_err);
      tick();
      check("frame_done_one_cycle", int'(bus.frame_done), 0);
      check("busy_idle", int'(bus.busy), 0);
      check("res_valid_idle", int'(bus.res_valid), 0);
      check("err_idle", int'(bus.err), exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int c;
      clk            = 1'b0;
      rst            = 1'b1;
      checks         = 0;
      errors         = 0;
      xfer_count     = 0;
      bus.start      = 1'b0;
      bus.part_valid = 1'b0;
      bus.res_idx    = 5'd0;
      bus.part_idx   = 2'd0;
      bus.part_data  = 6'd0;
      bus.res_ready  = 1'b0;
      #12;
      check("rst_res_valid", int'(bus.res_valid), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_err", int'(bus.err), 0);
      check("rst_frame_done", int'(bus.frame_done), 0);
      check("rst_res_addr", int'(bus.res_addr), 0);
      check("rst_res_data", int'(bus.res_data), 0);
      rst = 1'b0;

      // Stray beats in IDLE: no error, no state change.
      for (int k = 0; k < 3; k++) begin
         tick();
         bus.part_valid = 1'b1;
         bus.res_idx    = 5'(k + 4);
         bus.part_idx   = 2'(k);
         bus.part_data  = 6'(k + 1);
      end
      tick();
      bus.part_valid = 1'b0;
      check("idle_stray_err", int'(bus.err), 0);
      check("idle_stray_busy", int'(bus.busy), 0);

      // Clean frame, with an ignored start pulse mid-collection.
      start_frame();
      push_frame();
      send_frame(-1, 1'b1);
      drain(1'b0, 9, 0);

      // Backpressure: ready 1,0,0 repeating.
      bus.res_ready = 1'b0;
      start_frame();
      push_frame();
      send_frame(-1, 1'b0);
      drain(1'b1, 25, 0);

      // Order error on beat 4 (part 2 instead of 1); frame still completes.
      start_frame();
      push_frame();
      send_frame(4, 1'b0);
      drain(1'b0, 9, 1);

      // Overrun beat in DRAIN, then async reset after 4 transfers.
      bus.res_ready = 1'b0;
      start_frame();
      push_frame();
      send_frame(-1, 1'b0);
      tick();
      bus.part_valid = 1'b1;
      bus.res_idx    = 5'd0;
      bus.part_idx   = 2'd0;
      bus.part_data  = 6'h2a;
      tick();
      bus.part_valid = 1'b0;
      check("drain_overrun_err", int'(bus.err), 1);
      check("drain_overrun_valid", int'(bus.res_valid), 1);
      base = xfer_count;
      bus.res_ready = 1'b1;
      c = 0;
      while (xfer_count < base + 4 && c < 50) begin
         tick();
         c++;
      end
      check("transfers_before_reset", xfer_count - base, 4);
      bus.res_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_res_valid", int'(bus.res_valid), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_err", int'(bus.err), 0);
      check("midrst_res_addr", int'(bus.res_addr), 0);
      #1;
      rst = 1'b0;
      exp_q.delete();

      // Full frame after reset starts again from addr 0.
      start_frame();
      push_frame();
      send_frame(-1, 1'b0);
      drain(1'b0, 9, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
